// File: rtl/loader_pkg.sv
// Shared definitions for the memory loader controller.
//   - 3-bit state encodings and the state enum built from them
//   - address strides for the 32-bit instruction and 64-bit data memories
//   - max3() helper used to size the shared word/cycle counter
package loader_pkg;

  localparam logic [2:0] EncIdle     = 3'd0;
  localparam logic [2:0] EncLoad     = 3'd1;
  localparam logic [2:0] EncRun      = 3'd2;
  localparam logic [2:0] EncDumpRd   = 3'd3;
  localparam logic [2:0] EncDumpWait = 3'd4;
  localparam logic [2:0] EncDumpOut  = 3'd5;
  localparam logic [2:0] EncDone     = 3'd6;

  typedef enum logic [2:0] {
    StIdle     = EncIdle,
    StLoad     = EncLoad,
    StRun      = EncRun,
    StDumpRd   = EncDumpRd,
    StDumpWait = EncDumpWait,
    StDumpOut  = EncDumpOut,
    StDone     = EncDone
  } state_e;

  // Byte strides between consecutive words of each memory.
  localparam int unsigned IMEM_STRIDE = 4;
  localparam int unsigned DMEM_STRIDE = 8;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Down-counting cycle timer.
//   clk, arst_n : clock, asynchronous active-low reset
//   i_load      : load i_value and start counting
//   i_value     : cycles-minus-one until expiry
//   o_expire    : one-cycle pulse when the loaded count has elapsed
// After loading V, o_expire is high in the (V+1)-th cycle following the load edge.
module cycle_timer #(
  parameter int unsigned Width = 11
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             i_load,
  input  logic [Width-1:0] i_value,
  output logic             o_expire
);

  logic [Width-1:0] r_count;
  logic             r_running;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_count   <= '0;
      r_running <= 1'b0;
    end else if (i_load) begin
      r_count   <= i_value;
      r_running <= 1'b1;
    end else if (r_running) begin
      if (r_count == '0) begin
        r_running <= 1'b0;
      end else begin
        r_count <= r_count - Width'(1);
      end
    end
  end

  assign o_expire = r_running && (r_count == '0);

endmodule

// File: rtl/mem_loader_ctrl.sv
// Session controller: loads a program word stream into instruction memory, runs the
// CPU for a fixed number of cycles, then streams a block of data memory back out.
//   clk, arst_n                      : clock, asynchronous active-low reset
//   start                            : begins a session from IDLE or DONE
//   in_valid/in_ready/in_data/in_last     : 32-bit program stream (sink)
//   out_valid/out_ready/out_data/out_last : 64-bit dump stream (source)
//   busy, done, cpu_enable           : status and CPU enable
//   *_ext                            : instruction-memory external port (write only)
//   *_ext_2                          : data-memory external port (read only, 1-cycle latency)
module mem_loader_ctrl
  import loader_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 512,
  parameter int unsigned RUN_CYCLES = 1024,
  parameter int unsigned DUMP_WORDS = 16
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        cpu_enable,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  input  logic [31:0] rdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2
);

  localparam int unsigned CntW = $clog2(max3(IMEM_WORDS, DUMP_WORDS, RUN_CYCLES)) + 1;
  localparam logic [CntW-1:0] LastImem = CntW'(IMEM_WORDS - 1);
  localparam logic [CntW-1:0] LastDump = CntW'(DUMP_WORDS - 1);
  localparam logic [CntW-1:0] RunLoad  = CntW'(RUN_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic [63:0]     r_out_data;

  logic w_xfer;
  logic w_load_done;
  logic w_run_expire;
  logic w_unused_rdata;

  // Instruction memory is never read by the loader.
  assign w_unused_rdata = ^rdata_ext;

  assign w_xfer      = in_valid && in_ready;
  // Leave LOAD on an explicit last word or when the memory is full.
  assign w_load_done = w_xfer && (in_last || (r_cnt == LastImem));

  // Timer is armed on the LOAD->RUN edge so RUN lasts exactly RUN_CYCLES cycles.
  cycle_timer #(
    .Width(CntW)
  ) u_run_timer (
    .clk     (clk),
    .arst_n  (arst_n),
    .i_load  (w_load_done),
    .i_value (RunLoad),
    .o_expire(w_run_expire)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_out_data <= '0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (start) begin
            r_state <= StLoad;
            r_cnt   <= '0;
          end
        end
        StLoad: begin
          if (w_xfer) begin
            if (w_load_done) begin
              r_state <= StRun;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CntOne;
            end
          end
        end
        StRun: begin
          if (w_run_expire) begin
            r_state <= StDumpRd;
            r_cnt   <= '0;
          end
        end
        StDumpRd: begin
          r_state <= StDumpWait;
        end
        StDumpWait: begin
          r_out_data <= rdata_ext_2;
          r_state    <= StDumpOut;
        end
        StDumpOut: begin
          if (out_ready) begin
            if (r_cnt == LastDump) begin
              r_state <= StDone;
            end else begin
              r_cnt   <= r_cnt + CntOne;
              r_state <= StDumpRd;
            end
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign in_ready   = (r_state == StLoad);
  assign busy       = (r_state != StIdle) && (r_state != StDone);
  assign done       = (r_state == StDone);
  assign cpu_enable = (r_state == StRun);

  assign wen_ext   = w_xfer;
  assign wdata_ext = w_xfer ? in_data : 32'd0;
  assign addr_ext  = w_xfer ? (64'(r_cnt) * 64'(IMEM_STRIDE)) : 64'd0;
  assign ren_ext   = 1'b0;

  assign ren_ext_2   = (r_state == StDumpRd);
  assign addr_ext_2  = ren_ext_2 ? (64'(r_cnt) * 64'(DMEM_STRIDE)) : 64'd0;
  assign wen_ext_2   = 1'b0;
  assign wdata_ext_2 = 64'd0;

  assign out_valid = (r_state == StDumpOut);
  assign out_data  = r_out_data;
  assign out_last  = out_valid && (r_cnt == LastDump);

endmodule

// File: tb/tb_mem_loader_ctrl.sv
module tb_mem_loader_ctrl;

  localparam int unsigned ImemWords = 4;
  localparam int unsigned RunCycles = 10;
  localparam int unsigned DumpWords = 4;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic        out_last;
  logic        busy, done, cpu_enable;
  logic [63:0] addr_ext;
  logic        wen_ext, ren_ext;
  logic [31:0] wdata_ext;
  logic [31:0] rdata_ext = 32'd0;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2, ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic [63:0] rdata_ext_2 = 64'd0;

  always #5 clk = ~clk;

  mem_loader_ctrl #(
    .IMEM_WORDS(ImemWords),
    .RUN_CYCLES(RunCycles),
    .DUMP_WORDS(DumpWords)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .cpu_enable (cpu_enable),
    .addr_ext   (addr_ext),
    .wen_ext    (wen_ext),
    .ren_ext    (ren_ext),
    .wdata_ext  (wdata_ext),
    .rdata_ext  (rdata_ext),
    .addr_ext_2 (addr_ext_2),
    .wen_ext_2  (wen_ext_2),
    .ren_ext_2  (ren_ext_2),
    .wdata_ext_2(wdata_ext_2),
    .rdata_ext_2(rdata_ext_2)
  );

  int errors = 0;
  int checks = 0;
  int sess = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL [s%0d] %s: got %0h expected %0h", sess, name, act, exp);
    end
  endtask

  // Data memory: address sampled mid-cycle, data appears one clock later.
  logic [63:0] dmem[16];
  logic        rd_pend = 1'b0;
  logic [63:0] rd_addr = 64'd0;
  always @(negedge clk) begin
    rd_pend = ren_ext_2;
    rd_addr = addr_ext_2;
  end
  always @(posedge clk) begin
    rdata_ext_2 <= rd_pend ? dmem[rd_addr[6:3]] : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  // Monitor: logs every transaction and cycle stamps.
  int          cyc = 0;
  int          cpu_cnt, cpu_first, cpu_last, wr_last, rd_first;
  logic [63:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [63:0] rd_addr_q[$];
  logic [63:0] hs_data_q[$];
  logic        hs_last_q[$];
  logic        p_stall = 1'b0;
  logic [63:0] p_data = 64'd0;

  task automatic clear_logs();
    cpu_cnt = 0; cpu_first = -1; cpu_last = -1; wr_last = -1; rd_first = -1;
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    hs_data_q.delete(); hs_last_q.delete();
  endtask

  always @(negedge clk) begin
    cyc++;
    check("tied_off", {61'd0, wen_ext_2, ren_ext, |wdata_ext_2}, 64'd0);
    if (!wen_ext) check("addr_ext_idle", addr_ext, 64'd0);
    if (!ren_ext_2) check("addr_ext_2_idle", addr_ext_2, 64'd0);
    if (p_stall) begin
      check("stall_valid", {63'd0, out_valid}, 64'd1);
      check("stall_data", out_data, p_data);
      check("stall_no_read", {63'd0, ren_ext_2}, 64'd0);
    end
    p_stall = out_valid && !out_ready;
    p_data  = out_data;
    if (wen_ext) begin
      wr_addr_q.push_back(addr_ext);
      wr_data_q.push_back(wdata_ext);
      wr_last = cyc;
    end
    if (cpu_enable) begin
      if (cpu_cnt == 0) cpu_first = cyc;
      cpu_cnt++;
      cpu_last = cyc;
    end
    if (ren_ext_2) begin
      if (rd_addr_q.size() == 0) rd_first = cyc;
      rd_addr_q.push_back(addr_ext_2);
    end
    if (out_valid && out_ready) begin
      hs_data_q.push_back(out_data);
      hs_last_q.push_back(out_last);
    end
  end

  logic [31:0] words[8];

  // bp: 0 = out_ready held 1, 1 = random valid/ready, 2 = stall word 1 for 5 cycles
  task automatic run_session(input int n, input int last_idx, input int exp_w,
                             input int start_mid, input int bp);
    int i, guard, held, mid;
    clear_logs();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    i = 0; guard = 0; mid = 0;
    while (guard < 200) begin
      guard++;
      if (i < n) begin
        in_valid = (bp == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_data  = words[i];
        in_last  = (i == last_idx);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      if (start_mid != 0 && i == 1 && mid == 0) begin
        in_valid = 1'b0;
        start    = 1'b1;
        mid      = 1;
      end
      @(negedge clk);
      if (mid == 1) begin
        mid = 2;
      end else if (mid == 2) begin
        check("start_in_load_ready", {63'd0, in_ready}, 64'd1);
        check("start_in_load_busy", {63'd0, busy}, 64'd1);
        mid = 3;
      end
      if (!in_ready) break;
      if (in_valid) i++;
      @(posedge clk); #1 start = 1'b0;
    end
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
    check("in_ready_after_load", {63'd0, in_ready}, 64'd0);

    held = 0; guard = 0;
    while (!done && guard < 500) begin
      @(posedge clk); #1;
      guard++;
      if (bp == 2 && out_valid && hs_data_q.size() == 1 && held < 5) begin
        out_ready = 1'b0;
        held++;
      end else if (bp == 1) begin
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready = 1'b1;
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    check("reach_done", {63'd0, done}, 64'd1);
    check("done_not_busy", {63'd0, busy}, 64'd0);
    if (bp == 2) check("stall_cycles", held, 5);

    check("wr_count", wr_addr_q.size(), exp_w);
    for (int k = 0; k < exp_w && k < wr_addr_q.size(); k++) begin
      check("wr_addr", wr_addr_q[k], 64'(4 * k));
      check("wr_data", {32'd0, wr_data_q[k]}, {32'd0, words[k]});
    end
    check("load_to_run", cpu_first, wr_last + 1);
    check("cpu_cycles", cpu_cnt, RunCycles);
    check("run_to_read", rd_first, cpu_last + 1);
    check("rd_count", rd_addr_q.size(), DumpWords);
    for (int k = 0; k < DumpWords && k < rd_addr_q.size(); k++) begin
      check("rd_addr", rd_addr_q[k], 64'(8 * k));
    end
    check("dump_count", hs_data_q.size(), DumpWords);
    for (int k = 0; k < DumpWords && k < hs_data_q.size(); k++) begin
      check("dump_data", hs_data_q[k], dmem[k]);
      check("dump_last", {63'd0, hs_last_q[k]}, {63'd0, k == DumpWords - 1});
    end
  endtask

  typedef struct {
    int n;
    int last_idx;
    int exp_w;
    int start_mid;
    int bp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int n, li, ew, guard;

    tbl[0] = '{3, 2, 3, 0, 0};  // basic three-word program
    tbl[1] = '{6, -1, 4, 0, 0}; // no last: capacity limit
    tbl[2] = '{3, 2, 3, 0, 2};  // dump backpressure
    tbl[3] = '{4, 2, 3, 1, 0};  // start during LOAD ignored
    tbl[4] = '{2, 0, 1, 0, 1};  // single word, random handshakes
    tbl[5] = '{8, 5, 4, 0, 1};  // last beyond capacity

    for (int k = 0; k < 16; k++) dmem[k] = 64'h1000 + 64'(k);

    // In reset
    #12;
    check("rst_cpu_enable", {63'd0, cpu_enable}, 64'd0);
    check("rst_flags", {58'd0, in_ready, out_valid, out_last, busy, done, wen_ext}, 64'd0);
    check("rst_ren_ext_2", {63'd0, ren_ext_2}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    @(negedge clk) arst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", {63'd0, busy}, 64'd0);
    check("idle_done", {63'd0, done}, 64'd0);

    for (int t = 0; t < 6; t++) begin
      sess = t;
      for (int k = 0; k < 8; k++) words[k] = $urandom;
      if (t == 0) begin
        words[0] = 32'h0050_0093; words[1] = 32'h00a0_0113; words[2] = 32'h0020_81b3;
      end
      run_session(tbl[t].n, tbl[t].last_idx, tbl[t].exp_w, tbl[t].start_mid, tbl[t].bp);
    end

    // Reset while a word is being written in LOAD
    sess = 100;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    in_valid = 1'b1; in_data = 32'hCAFE_0001; in_last = 1'b0;
    @(negedge clk);
    check("pre_rst_wen", {63'd0, wen_ext}, 64'd1);
    #2 arst_n = 1'b0;
    #1;
    check("rst_load_wen", {63'd0, wen_ext}, 64'd0);
    check("rst_load_ready", {63'd0, in_ready}, 64'd0);
    check("rst_load_busy", {63'd0, busy}, 64'd0);
    @(negedge clk) arst_n = 1'b1;
    clear_logs();
    repeat (5) @(negedge clk);
    check("rst_no_writes", wr_addr_q.size(), 0);
    check("rst_stays_idle", {63'd0, busy}, 64'd0);

    // Reset during RUN
    sess = 101;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    guard = 0;
    while (!cpu_enable && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    check("reached_run", {63'd0, cpu_enable}, 64'd1);
    repeat (3) @(negedge clk);
    #2 arst_n = 1'b0;
    #1;
    check("rst_run_cpu_enable", {63'd0, cpu_enable}, 64'd0);
    check("rst_run_busy", {63'd0, busy}, 64'd0);
    check("rst_run_done", {63'd0, done}, 64'd0);
    @(negedge clk) arst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("post_rst_idle", {61'd0, cpu_enable, busy, out_valid}, 64'd0);

    // Randomized sessions against the reference rules
    for (int t = 0; t < 6; t++) begin
      sess = 200 + t;
      for (int k = 0; k < 16; k++) dmem[k] = {$urandom, $urandom};
      for (int k = 0; k < 8; k++) words[k] = $urandom;
      n  = $urandom_range(1, 7);
      li = $urandom_range(0, n);
      if (li == n) begin
        li = -1;
        if (n < ImemWords) n = ImemWords + $urandom_range(0, 3);
      end
      ew = (li >= 0 && li < ImemWords) ? li + 1 : ImemWords;
      run_session(n, li, ew, 0, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_loader_ctrl.md
MEM_LOADER_CTRL -- requirements
Module: mem_loader_ctrl

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 512: maximum 32-bit words loaded into instruction memory.
REQ-002 SHALL have parameter RUN_CYCLES, default 1024: number of clk cycles cpu_enable stays high.
REQ-003 SHALL have parameter DUMP_WORDS, default 16: number of 64-bit data-memory words read back.
REQ-004 SHALL use one clock and an asynchronous active-low reset: clk input 1, rising-edge clock; arst_n input 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle pulse that begins a session; honoured only in IDLE or DONE.
REQ-006 SHALL have port in_valid, input, 1 bit, plus in_ready output 1 bit, in_data input 32 bits, in_last input 1 bit: program word stream.
REQ-007 SHALL have port out_valid, output, 1 bit, plus out_ready input 1 bit, out_data output 64 bits, out_last output 1 bit: dump stream.
REQ-008 SHALL have port busy, output, 1 bit: high in every state except IDLE and DONE.
REQ-009 SHALL have port done, output, 1 bit: high while in DONE.
REQ-010 SHALL have port cpu_enable, output, 1 bit: drives the CPU enable input.
REQ-011 SHALL have ports addr_ext output 64, wen_ext output 1, ren_ext output 1, wdata_ext output 32, and rdata_ext input 32, connected to the instruction-memory external port.
REQ-012 SHALL have ports addr_ext_2 output 64, wen_ext_2 output 1, ren_ext_2 output 1, wdata_ext_2 output 64, and rdata_ext_2 input 64, connected to the data-memory external port.

Function
REQ-013 SHALL implement the states IDLE, LOAD, RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT and DONE.
REQ-014 SHALL go IDLE/DONE -> LOAD on start, clearing the word counter to 0.
REQ-015 SHALL assert in_ready in LOAD only; a transfer occurs on any cycle with in_valid && in_ready.
REQ-016 SHALL, for each LOAD transfer, combinationally drive wen_ext=1, wdata_ext=in_data and addr_ext=4*word_count in the same cycle, then increment the counter.
REQ-017 SHALL go LOAD -> RUN after a transfer with in_last=1, or after the transfer of word IMEM_WORDS-1 (this applies even if in_last=0; later stream words are not accepted).
REQ-018 SHALL hold cpu_enable=1 for exactly RUN_CYCLES cycles in RUN, then go to DUMP_RD with the counter cleared.
REQ-019 SHALL, in DUMP_RD, drive ren_ext_2=1 and addr_ext_2=8*word_count for one cycle, then go to DUMP_WAIT.
REQ-020 SHALL treat memory read latency as exactly one cycle: in DUMP_WAIT it captures rdata_ext_2 into out_data and goes to DUMP_OUT.
REQ-021 SHALL, in DUMP_OUT, hold out_valid=1 and keep out_data stable until out_ready=1; out_last=1 on word DUMP_WORDS-1.
REQ-022 SHALL, on an out_valid && out_ready handshake, go to DONE if it was the last word, else increment the counter and go to DUMP_RD.
REQ-023 SHALL keep wen_ext_2=0, wdata_ext_2=0 and ren_ext=0 at all times; addr_ext and addr_ext_2 are 0 when not in use.
REQ-024 SHALL ignore start when busy=1.
REQ-025 SHALL apply all counter arithmetic on $clog2(max(IMEM_WORDS, DUMP_WORDS, RUN_CYCLES))+1 bits, with addresses zero-extended to 64 bits; no wrap-around is reachable.

Reset
REQ-026 SHALL, on arst_n low, immediately (asynchronously) enter IDLE with counters, out_data and the capture register cleared.
REQ-027 SHALL drive cpu_enable=0, in_ready=0, out_valid=0, out_last=0, busy=0, done=0 and all memory strobes 0 while in reset.
REQ-028 SHALL, on reset mid-session, abandon the session: no partial write completes after reset asserts, and a fresh start is required.

Structure
REQ-029 SHALL place the state encoding (3-bit localparams) and the word strides (4, 8) in a shared package, loader_pkg.
REQ-030 SHALL implement the run timer as one sub-module, cycle_timer (load, count-down, expire pulse); everything else is flat.

Verification
REQ-031 SHALL cover: start; 3 words 0x00500093, 0x00a00113, 0x002081b3 with last on the 3rd -> wen_ext pulses at addr 0, 4, 8; the next cycle is RUN.
REQ-032 SHALL cover: with RUN_CYCLES=10 -> cpu_enable high exactly 10 cycles, then ren_ext_2 at addr 0 on the following cycle.
REQ-033 SHALL cover: data memory preloaded with word k = 0x1000+k and DUMP_WORDS=4, out_ready held 1 -> out_data 0x1000..0x1003, out_last on the 4th word, then done=1.
REQ-034 SHALL cover: out_ready held 0 for 5 cycles on word 1 -> out_valid stays high, out_data is stable, and no new ren_ext_2 is issued.
REQ-035 SHALL cover: IMEM_WORDS=4 with 6 words streamed and no in_last -> exactly 4 writes (addr 0..12), then in_ready=0 and RUN entered.
REQ-036 SHALL cover: arst_n pulsed low during RUN, and start pulsed during LOAD -> the reset gives cpu_enable=0 and IDLE immediately; the start during LOAD leaves the counter and state unchanged.
